// File: rtl/arithmetic_coder.sv
// arithmetic_coder
//   Two-phase static-model arithmetic encoder for an 8-bit symbol stream.
//   Phase 1 buffers up to MAX_SYMBOLS symbols and builds a 256-bin histogram.
//   Phase 2 (wr_complete_in) builds the cumulative table, then encodes the
//   buffer with 16-bit integer arithmetic coding. The result is streamed as
//   {E-1, E x {sym, cnt_hi, cnt_lo}, L_hi, L_lo, L code bytes}.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   symbol_in/valid_in  input symbol stream (accepted in IDLE only)
//   wr_complete_in    level, input finished -> encode; drop it in DONE to clear
//   next_in           consume data_out, advance one byte
//   data_out/valid_out  current output byte / stream ready with bytes left
//
// Configuration
//   AC_SIDE_CHANNEL_EN  adds per-step debug ports (s_*); coded bytes unchanged.
module arithmetic_coder #(
  parameter int MAX_SYMBOLS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  symbol_in,
  input  logic        valid_in,
  input  logic        wr_complete_in,
  input  logic        next_in,
  output logic [7:0]  data_out,
  output logic        valid_out
`ifdef AC_SIDE_CHANNEL_EN
  ,
  output logic [15:0] s_bits_out,
  output logic [4:0]  s_bits_count_out,
  output logic        s_bits_valid_out,
  output logic [3:0]  s_pending_out,
  output logic        s_pending_valid_out,
  output logic [15:0] s_upper_before,
  output logic [15:0] s_lower_before,
  output logic [15:0] s_prob_upper,
  output logic [15:0] s_prob_lower,
  output logic [16:0] s_range_inv,
  output logic        s_before_valid,
  output logic [15:0] s_upper_after,
  output logic [15:0] s_lower_after,
  output logic        s_after_valid
`endif
);

  localparam int CODE_DEPTH = 2 * MAX_SYMBOLS;
  localparam int SW = (MAX_SYMBOLS > 1) ? $clog2(MAX_SYMBOLS) : 1;
  localparam int CW = $clog2(CODE_DEPTH);
  localparam logic [15:0] MAX_N  = 16'(MAX_SYMBOLS);
  localparam logic [15:0] CODE_N = 16'(CODE_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CUM, S_LOAD, S_DIV, S_UPD, S_RENORM, S_EMIT,
    S_FLUSH, S_PAD, S_READY, S_DONE, S_CLEAR
  } state_t;

  typedef enum logic [2:0] {RD_E, RD_TAB, RD_LH, RD_LL, RD_CODE} rd_t;

  state_t state;
  rd_t    rd_ph, nx_ph;

  logic [7:0]  sym_mem  [MAX_SYMBOLS];
  logic [15:0] hist     [256];
  logic [15:0] cum_mem  [256];
  logic [7:0]  ent_sym  [256];
  logic [7:0]  code_mem [CODE_DEPTH];

  logic [15:0] n_sym, sym_i, acc, code_len;
  logic [8:0]  ent_n;
  logic [7:0]  cnt_i, clr_i;
  logic [15:0] low, high, pending;
  logic [32:0] dq_hi, dq_lo;   // dividend shifting out, quotient shifting in
  logic [15:0] dr_hi, dr_lo;   // partial remainders
  logic [5:0]  div_cnt;
  logic        emit_val, emit_first, ret_flush;
  logic [15:0] emit_cnt;       // opposite bits still owed
  logic [7:0]  bit_acc;
  logic [2:0]  bit_n;
  logic [8:0]  rd_ent, nx_ent;
  logic [1:0]  rd_part, nx_part;
  logic [15:0] rd_idx, nx_idx;

  // datapath helpers
  logic [7:0]  cur_sym;
  logic [15:0] c_lo, c_hi, lo_m, hi_m;
  logic [16:0] rng, t_hi, t_lo;
  logic        ge_hi, ge_lo, emit_bit, emit_last;
  logic [1:0]  ren_case;       // 0 none, 1 lower half, 2 upper half, 3 middle
  logic [7:0]  packed_byte;
  logic [8:0]  ent_tot;
  logic [7:0]  rd_sym, nx_byte;
  logic [15:0] rd_cnt;
  logic        nx_end;

  always_comb begin
    cur_sym = sym_mem[sym_i[SW-1:0]];
    c_lo    = cum_mem[cur_sym];
    c_hi    = c_lo + hist[cur_sym];
    rng     = {1'b0, high} - {1'b0, low} + 17'd1;
    t_hi    = {dr_hi, dq_hi[32]};
    t_lo    = {dr_lo, dq_lo[32]};
    ge_hi   = t_hi >= {1'b0, n_sym};
    ge_lo   = t_lo >= {1'b0, n_sym};
    lo_m    = low - 16'h4000;
    hi_m    = high - 16'h4000;
    if (high < 16'h8000)                         ren_case = 2'd1;
    else if (low >= 16'h8000)                    ren_case = 2'd2;
    else if (low >= 16'h4000 && high < 16'hC000) ren_case = 2'd3;
    else                                         ren_case = 2'd0;
    emit_bit    = emit_first ? emit_val : ~emit_val;
    emit_last   = emit_first ? (emit_cnt == 16'd0) : (emit_cnt == 16'd1);
    packed_byte = {bit_acc[6:0], emit_bit};
  end

  // Next readout position and the byte found there. With an empty message
  // the table still carries one dummy entry {00, 0000}.
  always_comb begin
    ent_tot = (ent_n == 9'd0) ? 9'd1 : ent_n;
    nx_ph   = rd_ph;
    nx_ent  = rd_ent;
    nx_part = rd_part;
    nx_idx  = rd_idx;
    nx_end  = 1'b0;
    case (rd_ph)
      RD_E:    begin nx_ph = RD_TAB; nx_ent = '0; nx_part = '0; end
      RD_TAB:  if (rd_part != 2'd2) nx_part = rd_part + 2'd1;
               else if (rd_ent + 9'd1 < ent_tot) begin
                 nx_ent = rd_ent + 9'd1; nx_part = '0;
               end else nx_ph = RD_LH;
      RD_LH:   nx_ph = RD_LL;
      RD_LL:   if (code_len == 16'd0) nx_end = 1'b1;
               else begin nx_ph = RD_CODE; nx_idx = '0; end
      RD_CODE: if (rd_idx + 16'd1 < code_len) nx_idx = rd_idx + 16'd1;
               else nx_end = 1'b1;
      default: nx_end = 1'b1;
    endcase
    rd_sym = (ent_n == 9'd0) ? 8'd0 : ent_sym[nx_ent[7:0]];
    rd_cnt = hist[rd_sym];
    case (nx_ph)
      RD_TAB:  nx_byte = (nx_part == 2'd0) ? rd_sym :
                         (nx_part == 2'd1) ? rd_cnt[15:8] : rd_cnt[7:0];
      RD_LH:   nx_byte = code_len[15:8];
      RD_LL:   nx_byte = code_len[7:0];
      RD_CODE: nx_byte = code_mem[nx_idx[CW-1:0]];
      default: nx_byte = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_ph      <= RD_E;
      for (int i = 0; i < 256; i++) hist[i] <= '0;
      n_sym      <= '0;
      sym_i      <= '0;
      acc        <= '0;
      code_len   <= '0;
      ent_n      <= '0;
      cnt_i      <= '0;
      clr_i      <= '0;
      low        <= '0;
      high       <= 16'hFFFF;
      pending    <= '0;
      dq_hi      <= '0;
      dq_lo      <= '0;
      dr_hi      <= '0;
      dr_lo      <= '0;
      div_cnt    <= '0;
      emit_val   <= 1'b0;
      emit_first <= 1'b0;
      emit_cnt   <= '0;
      ret_flush  <= 1'b0;
      bit_acc    <= '0;
      bit_n      <= '0;
      rd_ent     <= '0;
      rd_part    <= '0;
      rd_idx     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in && n_sym < MAX_N) begin
            sym_mem[n_sym[SW-1:0]] <= symbol_in;
            hist[symbol_in]        <= hist[symbol_in] + 16'd1;
            n_sym                  <= n_sym + 16'd1;
          end
          if (wr_complete_in) begin
            state    <= S_CUM;
            cnt_i    <= '0;
            acc      <= '0;
            ent_n    <= '0;
            sym_i    <= '0;
            code_len <= '0;
            bit_n    <= '0;
            bit_acc  <= '0;
            low      <= '0;
            high     <= 16'hFFFF;
            pending  <= '0;
          end
        end
        // one bin per cycle: cumulative counts and the ascending entry list
        S_CUM: begin
          cum_mem[cnt_i] <= acc;
          acc            <= acc + hist[cnt_i];
          if (hist[cnt_i] != 16'd0) begin
            ent_sym[ent_n[7:0]] <= cnt_i;
            ent_n               <= ent_n + 9'd1;
          end
          cnt_i <= cnt_i + 8'd1;
          if (cnt_i == 8'hFF) state <= (n_sym == 16'd0) ? S_PAD : S_LOAD;
        end
        S_LOAD: begin
          dq_hi   <= 33'(rng) * 33'(c_hi);
          dq_lo   <= 33'(rng) * 33'(c_lo);
          dr_hi   <= '0;
          dr_lo   <= '0;
          div_cnt <= '0;
          state   <= S_DIV;
        end
        // restoring shift-subtract, one quotient bit per cycle, both bounds
        S_DIV: begin
          dr_hi   <= ge_hi ? 16'(t_hi - {1'b0, n_sym}) : t_hi[15:0];
          dr_lo   <= ge_lo ? 16'(t_lo - {1'b0, n_sym}) : t_lo[15:0];
          dq_hi   <= {dq_hi[31:0], ge_hi};
          dq_lo   <= {dq_lo[31:0], ge_lo};
          div_cnt <= div_cnt + 6'd1;
          if (div_cnt == 6'd32) state <= S_UPD;
        end
        S_UPD: begin
          high  <= 16'({2'b0, low} + dq_hi[17:0] - 18'd1);
          low   <= 16'({2'b0, low} + dq_lo[17:0]);
          state <= S_RENORM;
        end
        // subtracting 0x8000 before the shift only drops bit 15, so both
        // emitting cases share the same shift
        S_RENORM: begin
          case (ren_case)
            2'd1, 2'd2: begin
              emit_val   <= (ren_case == 2'd2);
              emit_cnt   <= pending;
              emit_first <= 1'b1;
              ret_flush  <= 1'b0;
              pending    <= '0;
              low        <= {low[14:0], 1'b0};
              high       <= {high[14:0], 1'b1};
              state      <= S_EMIT;
            end
            2'd3: begin
              pending <= pending + 16'd1;
              low     <= {lo_m[14:0], 1'b0};
              high    <= {hi_m[14:0], 1'b1};
            end
            default: begin
              if (sym_i == n_sym - 16'd1) state <= S_FLUSH;
              else begin
                sym_i <= sym_i + 16'd1;
                state <= S_LOAD;
              end
            end
          endcase
        end
        // one bit per cycle into the MSB-first byte packer
        S_EMIT: begin
          bit_acc <= packed_byte;
          bit_n   <= bit_n + 3'd1;
          if (bit_n == 3'd7 && code_len < CODE_N) begin
            code_mem[code_len[CW-1:0]] <= packed_byte;
            code_len                   <= code_len + 16'd1;
          end
          if (emit_first) emit_first <= 1'b0;
          else            emit_cnt   <= emit_cnt - 16'd1;
          if (emit_last) state <= ret_flush ? S_PAD : S_RENORM;
        end
        S_FLUSH: begin
          emit_val   <= (low >= 16'h4000);
          emit_cnt   <= pending + 16'd1;
          emit_first <= 1'b1;
          ret_flush  <= 1'b1;
          pending    <= '0;
          state      <= S_EMIT;
        end
        S_PAD: begin
          if (bit_n != 3'd0 && code_len < CODE_N) begin
            code_mem[code_len[CW-1:0]] <= bit_acc << (4'd8 - {1'b0, bit_n});
            code_len                   <= code_len + 16'd1;
          end
          bit_n     <= '0;
          rd_ph     <= RD_E;
          data_out  <= (ent_n == 9'd0) ? 8'd0 : 8'(ent_n - 9'd1);
          valid_out <= 1'b1;
          state     <= S_READY;
        end
        S_READY: begin
          if (next_in) begin
            if (nx_end) begin
              data_out  <= 8'd0;
              valid_out <= 1'b0;
              state     <= S_DONE;
            end else begin
              rd_ph    <= nx_ph;
              rd_ent   <= nx_ent;
              rd_part  <= nx_part;
              rd_idx   <= nx_idx;
              data_out <= nx_byte;
            end
          end
        end
        S_DONE: begin
          if (!wr_complete_in) begin
            clr_i    <= '0;
            n_sym    <= '0;
            code_len <= '0;
            ent_n    <= '0;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          hist[clr_i] <= '0;
          clr_i       <= clr_i + 8'd1;
          if (clr_i == 8'hFF) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AC_SIDE_CHANNEL_EN
  logic [15:0] sb_bits;
  logic [4:0]  sb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_bits             <= '0;
      sb_cnt              <= '0;
      s_bits_out          <= '0;
      s_bits_count_out    <= '0;
      s_bits_valid_out    <= 1'b0;
      s_pending_out       <= '0;
      s_pending_valid_out <= 1'b0;
      s_upper_before      <= '0;
      s_lower_before      <= '0;
      s_prob_upper        <= '0;
      s_prob_lower        <= '0;
      s_range_inv         <= '0;
      s_before_valid      <= 1'b0;
      s_upper_after       <= '0;
      s_lower_after       <= '0;
      s_after_valid       <= 1'b0;
    end else begin
      s_bits_valid_out    <= 1'b0;
      s_pending_valid_out <= 1'b0;
      s_before_valid      <= 1'b0;
      s_after_valid       <= 1'b0;
      case (state)
        S_LOAD: begin
          s_upper_before <= high;
          s_lower_before <= low;
          s_prob_upper   <= c_hi;
          s_prob_lower   <= c_lo;
          s_range_inv    <= rng;
          s_before_valid <= 1'b1;
        end
        S_RENORM: begin
          if (ren_case != 2'd0) begin
            s_pending_out       <= (ren_case == 2'd3) ? 4'(pending + 16'd1) : 4'd0;
            s_pending_valid_out <= 1'b1;
            sb_bits             <= '0;
            sb_cnt              <= '0;
          end else begin
            s_upper_after <= high;
            s_lower_after <= low;
            s_after_valid <= 1'b1;
          end
        end
        S_FLUSH: begin
          sb_bits <= '0;
          sb_cnt  <= '0;
        end
        S_EMIT: begin
          sb_bits <= {sb_bits[14:0], emit_bit};
          if (sb_cnt != 5'd16) sb_cnt <= sb_cnt + 5'd1;
          if (emit_last) begin
            s_bits_out       <= {sb_bits[14:0], emit_bit};
            s_bits_count_out <= (sb_cnt != 5'd16) ? sb_cnt + 5'd1 : sb_cnt;
            s_bits_valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_arithmetic_coder.sv
module tb_arithmetic_coder;

  localparam int MAXS = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] symbol_in;
  logic       valid_in;
  logic       wr_complete_in;
  logic       next_in;
  logic [7:0] data_out;
  logic       valid_out;

  int errors = 0;
  int checks = 0;

  byte unsigned msg[$];
  logic [7:0]   exp_q[$];

  arithmetic_coder #(.MAX_SYMBOLS(MAXS)) dut (
    .clk(clk), .rst(rst), .symbol_in(symbol_in), .valid_in(valid_in),
    .wr_complete_in(wr_complete_in), .next_in(next_in),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {valid,data}=%03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  // Reference encoder straight from the algorithm description.
  task automatic model_push();
    int unsigned cnt[256];
    int unsigned cum[256];
    int unsigned n, e, a, nbytes;
    longint unsigned low, high, rng;
    int unsigned pend;
    bit bits[$];
    logic [7:0] b;
    n = (msg.size() > MAXS) ? MAXS : msg.size();
    for (int s = 0; s < 256; s++) cnt[s] = 0;
    for (int i = 0; i < int'(n); i++) cnt[msg[i]]++;
    a = 0; e = 0;
    for (int s = 0; s < 256; s++) begin
      cum[s] = a; a += cnt[s];
      if (cnt[s] != 0) e++;
    end
    exp_q.push_back((e == 0) ? 8'd0 : 8'(e - 1));
    if (e == 0) begin
      exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    end else
      for (int s = 0; s < 256; s++)
        if (cnt[s] != 0) begin
          exp_q.push_back(8'(s));
          exp_q.push_back(8'(cnt[s] >> 8));
          exp_q.push_back(8'(cnt[s] & 255));
        end
    low = 0; high = 64'hFFFF; pend = 0;
    for (int i = 0; i < int'(n); i++) begin
      rng  = high - low + 1;
      high = low + rng * (cum[msg[i]] + cnt[msg[i]]) / n - 1;
      low  = low + rng * cum[msg[i]] / n;
      while (1) begin
        if (high < 64'h8000) begin
          bits.push_back(1'b0); repeat (pend) bits.push_back(1'b1); pend = 0;
        end else if (low >= 64'h8000) begin
          bits.push_back(1'b1); repeat (pend) bits.push_back(1'b0); pend = 0;
          low -= 64'h8000; high -= 64'h8000;
        end else if (low >= 64'h4000 && high < 64'hC000) begin
          pend++; low -= 64'h4000; high -= 64'h4000;
        end else break;
        low  = (low << 1) & 64'hFFFF;
        high = ((high << 1) | 1) & 64'hFFFF;
      end
    end
    if (n > 0) begin
      pend++;
      if (low < 64'h4000) begin bits.push_back(1'b0); repeat (pend) bits.push_back(1'b1); end
      else begin bits.push_back(1'b1); repeat (pend) bits.push_back(1'b0); end
    end
    nbytes = (bits.size() + 7) / 8;
    exp_q.push_back(8'(nbytes >> 8));
    exp_q.push_back(8'(nbytes & 255));
    for (int k = 0; k < int'(nbytes); k++) begin
      b = 8'd0;
      for (int j = 0; j < 8; j++)
        if (k * 8 + j < bits.size()) b[7-j] = bits[k*8+j];
      exp_q.push_back(b);
    end
  endtask

  task automatic send_msg();
    foreach (msg[i]) begin
      @(negedge clk); symbol_in = msg[i]; valid_in = 1'b1;
    end
    @(negedge clk); valid_in = 1'b0; wr_complete_in = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int guard = 0;
    while (valid_out !== 1'b1 && guard < 20000) begin @(negedge clk); guard++; end
    check9({tag, "_ready"}, {valid_out, 8'h00}, {1'b1, 8'h00});
  endtask

  // Pops the scoreboard against the stream, with next_in held high.
  task automatic drain(input string tag);
    logic [7:0] e;
    int k = 0;
    wait_valid(tag);
    if (valid_out !== 1'b1) exp_q.delete();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check9($sformatf("%s_b%0d", tag, k), {valid_out, data_out}, {1'b1, e});
      next_in = 1'b1;
      @(negedge clk);
      k++;
    end
    next_in = 1'b0;
    check9({tag, "_end"}, {valid_out, data_out}, 9'h000);
  endtask

  task automatic release_run();
    wr_complete_in = 1'b0;
    repeat (300) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; symbol_in = '0; valid_in = 1'b0; wr_complete_in = 1'b0; next_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check9("reset", {valid_out, data_out}, 9'h000);

    load_str("AAAA");
    exp_q = '{8'h00, 8'h41, 8'h00, 8'h04, 8'h00, 8'h01, 8'h40};
    send_msg(); drain("aaaa"); release_run();

    load_str("AB");
    exp_q = '{8'h01, 8'h41, 8'h00, 8'h01, 8'h42, 8'h00, 8'h01, 8'h00, 8'h01, 8'h50};
    send_msg(); drain("ab"); release_run();

    msg.delete();
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_msg(); drain("empty"); release_run();

    load_str("The quick brown fox jumps over the lazy dog; pack my box with five dozen liquor jugs, said Alice!");
    model_push(); send_msg(); drain("sentence"); release_run();

    msg.delete();
    for (int i = 0; i < 130; i++) msg.push_back(8'($urandom_range(65, 72)));
    model_push(); send_msg(); drain("overflow"); release_run();

    load_str("AAAA");
    exp_q = '{8'h00, 8'h41, 8'h00, 8'h04, 8'h00, 8'h01, 8'h40};
    send_msg(); drain("aaaa_again"); release_run();

    // reset while encoding
    load_str("The quick brown fox jumps over the lazy dog");
    send_msg();
    repeat (60) @(negedge clk);
    rst = 1'b1; #1;
    check9("rst_encode", {valid_out, data_out}, 9'h000);
    wr_complete_in = 1'b0;
    @(negedge clk); rst = 1'b0;

    // reset mid-readout
    load_str("AB");
    send_msg(); wait_valid("ab_pre");
    check9("ab_first", {valid_out, data_out}, {1'b1, 8'h01});
    rst = 1'b1; #1;
    check9("rst_readout", {valid_out, data_out}, 9'h000);
    wr_complete_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    load_str("AB");
    exp_q = '{8'h01, 8'h41, 8'h00, 8'h01, 8'h42, 8'h00, 8'h01, 8'h00, 8'h01, 8'h50};
    send_msg(); drain("ab_after_rst"); release_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
